// File: rtl/ffo_pkg.sv
// Shared types and sizes for the 32-bit find-first-one scanner.
package ffo_pkg;

  localparam int W  = 32;
  localparam int PW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Bit 0 is the MSB; index i refers to element [i] of these vectors.
  typedef logic [0:W-1]  word_t;
  typedef logic [0:PW-1] idx_t;

endpackage

// File: rtl/ffo32_comb.sv
// Purely combinational 32-bit find-first-one tree.
// Finds the lowest-numbered set bit of b ([0:31] numbering, bit 0 = MSB).
// Five levels: 2-bit leaves, then four 2-input merges; left child wins.
module ffo32_comb
  import ffo_pkg::*;
(
  input  word_t b,
  output logic  v,
  output idx_t  p
);

  logic       l1_v [16];
  logic [0:0] l1_p [16];
  logic       l2_v [8];
  logic [1:0] l2_p [8];
  logic       l3_v [4];
  logic [2:0] l3_p [4];
  logic       l4_v [2];
  logic [3:0] l4_p [2];
  logic       l5_v;
  logic [4:0] l5_p;

  for (genvar k = 0; k < 16; k++) begin : g_leaf
    assign l1_v[k] = b[2*k] | b[2*k+1];
    assign l1_p[k] = !b[2*k];
  end

  for (genvar k = 0; k < 8; k++) begin : g_m2
    assign l2_v[k] = l1_v[2*k] | l1_v[2*k+1];
    assign l2_p[k] = l1_v[2*k] ? {1'b0, l1_p[2*k]} : {1'b1, l1_p[2*k+1]};
  end

  for (genvar k = 0; k < 4; k++) begin : g_m3
    assign l3_v[k] = l2_v[2*k] | l2_v[2*k+1];
    assign l3_p[k] = l2_v[2*k] ? {1'b0, l2_p[2*k]} : {1'b1, l2_p[2*k+1]};
  end

  for (genvar k = 0; k < 2; k++) begin : g_m4
    assign l4_v[k] = l3_v[2*k] | l3_v[2*k+1];
    assign l4_p[k] = l3_v[2*k] ? {1'b0, l3_p[2*k]} : {1'b1, l3_p[2*k+1]};
  end

  assign l5_v = l4_v[0] | l4_v[1];
  assign l5_p = l4_v[0] ? {1'b0, l4_p[0]} : {1'b1, l4_p[1]};

  assign v = l5_v;
  assign p = l5_p;

endmodule

// File: rtl/ffo32_scanner.sv
// Accepts a 32-bit word and emits the index of each set bit, one per beat,
// in ascending index order. An all-zero word yields a single "none" beat.
module ffo32_scanner
  import ffo_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  word_t in_word,
  output logic  out_valid,
  input  logic  out_ready,
  output idx_t  out_idx,
  output idx_t  out_seq,
  output logic  out_last,
  output logic  out_none
);

  scan_state_t r_state, w_state_nxt;
  word_t       r_work,  w_work_nxt;
  idx_t        r_seq,   w_seq_nxt;
  logic        r_zero,  w_zero_nxt;

  logic  w_ffo_v;
  idx_t  w_ffo_p;
  word_t w_cleared;
  logic  w_beat;
  logic  w_accept;

  ffo32_comb u_ffo (
    .b (r_work),
    .v (w_ffo_v),
    .p (w_ffo_p)
  );

  assign out_valid = (r_state == SCAN) && !reset;
  assign out_idx   = (r_zero || !w_ffo_v) ? '0 : w_ffo_p;
  assign out_seq   = r_seq;
  assign out_none  = r_zero;
  assign out_last  = r_zero || (w_cleared == '0);

  assign w_beat    = out_valid && out_ready;
  assign in_ready  = !reset && ((r_state == IDLE) || (w_beat && out_last));
  assign w_accept  = in_valid && in_ready;

  // Remaining work once the bit being presented this beat is retired.
  always_comb begin
    w_cleared = r_work;
    w_cleared[out_idx] = 1'b0;
  end

  // Next-state: retire a beat, finish a word, and/or load a new one.
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_seq_nxt   = r_seq;
    w_zero_nxt  = r_zero;
    if (w_beat) begin
      if (!out_last) begin
        w_work_nxt = w_cleared;
        w_seq_nxt  = r_seq + idx_t'(1);
      end else begin
        w_state_nxt = IDLE;
        w_work_nxt  = '0;
        w_seq_nxt   = '0;
        w_zero_nxt  = 1'b0;
      end
    end
    if (w_accept) begin
      w_state_nxt = SCAN;
      w_work_nxt  = in_word;
      w_seq_nxt   = '0;
      w_zero_nxt  = (in_word == '0);
    end
  end

  // State register; reset abandons any word in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_seq   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_seq   <= w_seq_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

endmodule
